// File: rtl/term_in_fifo.sv
// Terminal ingress FIFO: first-word-fall-through circular buffer with
// occupancy flags, sticky overflow/underflow and saturating statistics.
module term_in_fifo #(
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [pckg_sz-1:0]            data_in,
  output logic                          full,
  output logic                          almost_full,
  input  logic                          popin,
  output logic [pckg_sz-1:0]            data_out_i_in,
  output logic                          pndng_i_in,
  output logic [$clog2(fifo_depth):0]   count,
  output logic                          ovf,
  output logic                          udf,
  input  logic                          clr_err,
  output logic [CNT_W-1:0]              pushed_cnt,
  output logic [CNT_W-1:0]              popped_cnt,
  output logic [CNT_W-1:0]              drop_cnt
);
  localparam int AW = $clog2(fifo_depth);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

  state_t             r_state, w_state_nxt;
  logic [pckg_sz-1:0] r_mem [fifo_depth];
  logic [AW-1:0]      r_wr, r_rd;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic               r_ovf, r_udf;
  logic [CNT_W-1:0]   r_pushed, r_popped, r_drop;
  logic               w_do_push, w_do_pop, w_drop, w_udf_ev;

  // state register; mirrors occupancy class of r_cnt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // next-state: per-state accept/pop/drop decisions and resulting occupancy
  always_comb begin
    w_do_push = 1'b0;
    w_do_pop  = 1'b0;
    w_drop    = 1'b0;
    w_udf_ev  = 1'b0;
    unique case (r_state)
      S_EMPTY: begin
        w_do_push = push;
        w_udf_ev  = popin;              // pop ignored, push still lands
      end
      S_PARTIAL: begin
        w_do_push = push;
        w_do_pop  = popin;
      end
      default: begin                    // S_FULL
        w_do_pop  = popin;
        w_do_push = push & popin;       // freed slot takes the push
        w_drop    = push & ~popin;
      end
    endcase
    w_cnt_nxt = r_cnt;
    if (w_do_push && !w_do_pop)      w_cnt_nxt = r_cnt + CW'(1);
    else if (w_do_pop && !w_do_push) w_cnt_nxt = r_cnt - CW'(1);
    if (w_cnt_nxt == CW'(0))               w_state_nxt = S_EMPTY;
    else if (w_cnt_nxt == CW'(fifo_depth)) w_state_nxt = S_FULL;
    else                                   w_state_nxt = S_PARTIAL;
  end

  // outputs: all derived from registered state only
  always_comb begin
    full          = (r_state == S_FULL);
    pndng_i_in    = (r_state != S_EMPTY);
    almost_full   = (r_cnt >= CW'(fifo_depth - 1));
    data_out_i_in = pndng_i_in ? r_mem[r_rd] : '0;
    count         = r_cnt;
    ovf           = r_ovf;
    udf           = r_udf;
    pushed_cnt    = r_pushed;
    popped_cnt    = r_popped;
    drop_cnt      = r_drop;
  end

  // pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      r_cnt <= w_cnt_nxt;
    end
  end

  // storage has no reset; contents are only visible while occupied
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= data_in;
  end

  // sticky error flags and saturating statistics; clear beats any event
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_pushed <= '0;
      r_popped <= '0;
      r_drop   <= '0;
    end else if (clr_err) begin
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_pushed <= '0;
      r_popped <= '0;
      r_drop   <= '0;
    end else begin
      if (w_drop)   r_ovf <= 1'b1;
      if (w_udf_ev) r_udf <= 1'b1;
      if (w_do_push && r_pushed != '1) r_pushed <= r_pushed + CNT_W'(1);
      if (w_do_pop  && r_popped != '1) r_popped <= r_popped + CNT_W'(1);
      if (w_drop    && r_drop   != '1) r_drop   <= r_drop   + CNT_W'(1);
    end
  end

endmodule

// File: doc/term_in_fifo.md
Name: term_in_fifo

Overview:
- Terminal-side ingress FIFO; one instance per mesh terminal, ROWS*2+COLUMS*2 instances total.
- The terminal agent pushes packets in; the mesh_gnrtr terminal port drains them through its popin/pndng_i_in/data_out_i_in handshake.
- First-word-fall-through buffer with occupancy reporting, overflow drop, underflow detection and per-terminal statistics counters for the checker.

Parameters:
- pckg_sz, 40, packet width in bits.
- fifo_depth, 4, number of entries; power of two, at least 2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- push  input  1  terminal agent writes data_in this cycle.
- data_in  input  pckg_sz  packet from the terminal agent.
- full  output  1  occupancy equals fifo_depth.
- almost_full  output  1  occupancy is at least fifo_depth-1.
- popin  input  1  router consumes the head entry this cycle.
- data_out_i_in  output  pckg_sz  head entry (FWFT); zero when empty.
- pndng_i_in  output  1  FIFO non-empty.
- count  output  $clog2(fifo_depth)+1  current occupancy.
- ovf  output  1  sticky; set by a push dropped while full.
- udf  output  1  sticky; set by a popin while empty.
- clr_err  input  1  synchronous clear of ovf/udf and of all statistics counters.
- pushed_cnt  output  CNT_W  accepted pushes.
- popped_cnt  output  CNT_W  completed pops.
- drop_cnt  output  CNT_W  dropped pushes.

Behaviour:
- Reset (asynchronous, active-high): pointers=0, count=0, pndng_i_in=0, full=0, almost_full=0, data_out_i_in=0, ovf=0, udf=0, all counters=0. Storage contents are don't-care.
- Reset asserted mid-transfer: the in-flight entry is discarded. No pop is reported after release.
- Storage: circular buffer with wr_ptr and rd_ptr, each $clog2(fifo_depth) bits, wrapping from fifo_depth-1 to 0.
- Occupancy: tracked in count. full is (count==fifo_depth). pndng_i_in is (count!=0). All flags are registered-state derived, with no combinational path from push or popin.
- FWFT: data_out_i_in = mem[rd_ptr] when count!=0, else all zeros.
- Latency: a push in cycle N is visible on pndng_i_in/data_out_i_in in cycle N+1. Push-to-head latency is 1 cycle when the FIFO is empty.
- Internal state machine, EMPTY / PARTIAL / FULL, derived from count:
  - EMPTY, push -> PARTIAL.
  - EMPTY, popin -> stays EMPTY; udf set; no pointer move.
  - PARTIAL, push only -> count+1; becomes FULL when count reaches fifo_depth.
  - PARTIAL, popin only -> count-1; becomes EMPTY when count reaches 0.
  - PARTIAL, push and popin -> both pointers advance; count unchanged.
  - FULL, push only -> data dropped; ovf set; drop_cnt+1.
  - FULL, push and popin -> pop completes and the push is accepted in the freed slot; count stays fifo_depth; no drop.
  - EMPTY, push and popin -> popin ignored; udf set; push accepted; count=1.
- Counters: pushed_cnt increments on each accepted push, popped_cnt on each completed pop, drop_cnt on each dropped push. All saturate at 2^CNT_W-1 (no wrap).
- clr_err: the cycle's own push/pop still complete; counters and sticky flags read 0 next cycle. If clr_err coincides with an error event, the clear wins.
- Data integrity: strict FIFO order; no entry is duplicated or reordered across pointer wrap-around.

Test Plan:
- Reset then idle 5 cycles -> pndng_i_in=0, data_out_i_in=0, count=0, all flags and counters 0.
- Push 40'hA5_0000_0001..0004 on consecutive cycles, no popin -> full=1 after the 4th push (almost_full=1 after the 3rd). A 5th push of 40'hFF.. -> ovf=1, drop_cnt=1, and head stays 40'hA5_0000_0001.
- From full, popin each cycle for 4 cycles -> data_out_i_in sequence 0001, 0002, 0003, 0004; pndng_i_in=0 on the 5th cycle; popped_cnt=4.
- Continuous push+popin for 10 cycles starting with count=2 -> count stays 2, pointers wrap twice, output order matches input order, no ovf/udf.
- popin while empty, then push+popin together while empty -> udf=1, count=1, pushed_cnt=1, popped_cnt=0; then clr_err -> udf=0, counters=0 next cycle.
- Assert reset for 1 cycle with count=3 -> count=0 and pndng_i_in=0 immediately (asynchronous). The first push after release appears at the head one cycle later.
